// File: rtl/lift_dispatcher_if.sv
// ----------------------------------------------------------------------------
// lift_dispatcher_if : hall-call handshake, lift status and assignment bus
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface lift_dispatcher_if;
    logic       hall_valid;
    logic [2:0] hall_floor;
    logic       hall_ready;
    logic [2:0] current_floor1;
    logic [2:0] current_floor2;
    logic [1:0] status1;
    logic [1:0] status2;
    logic       emergency_stop1;
    logic       emergency_stop2;
    logic       full_capacity1;
    logic       full_capacity2;
    logic       assign_valid1;
    logic       assign_valid2;
    logic [2:0] assign_floor1;
    logic [2:0] assign_floor2;
    logic [7:0] pending;
    logic [7:0] assign_count1;
    logic [7:0] assign_count2;

    modport master (
        output hall_valid, hall_floor, current_floor1, current_floor2,
               status1, status2, emergency_stop1, emergency_stop2,
               full_capacity1, full_capacity2,
        input  hall_ready, assign_valid1, assign_valid2, assign_floor1,
               assign_floor2, pending, assign_count1, assign_count2
    );

    modport slave (
        input  hall_valid, hall_floor, current_floor1, current_floor2,
               status1, status2, emergency_stop1, emergency_stop2,
               full_capacity1, full_capacity2,
        output hall_ready, assign_valid1, assign_valid2, assign_floor1,
               assign_floor2, pending, assign_count1, assign_count2
    );
endinterface

`default_nettype wire

// File: rtl/lift_dispatcher.sv
// ----------------------------------------------------------------------------
// lift_dispatcher : two-lift hall-call dispatcher, round-robin floor pick and
// nearest-eligible lift. Optional DISPATCH_AGE_EN adds per-floor call ageing.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module lift_dispatcher #(
    parameter int unsigned AGE_LIMIT = 15
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    lift_dispatcher_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [2:0] rr_ptr_q, rr_ptr_d;
    logic [2:0] cand_q, cand_d;
    logic       last_q, last_d;     // 1 = lift 2 won the previous assignment
    logic       win_q, win_d;       // 1 = lift 2 holds the current assignment
    logic       valid1_q, valid1_d, valid2_q, valid2_d;
    logic [2:0] floor1_q, floor1_d, floor2_q, floor2_d;
    logic [7:0] count1_q, count1_d, count2_q, count2_d;

    logic       accept;
    logic [7:0] set_mask;
    logic [2:0] diff1, diff2;
    logic [3:0] cost1, cost2;
    logic       elig1, elig2, pick2;
    logic       urgent_any;
    logic [2:0] urgent_idx;

    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [2:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign bus.hall_ready = ~pending_q[bus.hall_floor];
    assign accept         = bus.hall_valid & ~pending_q[bus.hall_floor];
    assign set_mask       = accept ? (8'b1 << bus.hall_floor) : 8'b0;

`ifdef DISPATCH_AGE_EN
    localparam logic [7:0] AGE_LIM8 = 8'(AGE_LIMIT);
    logic [7:0] age_q [8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) age_q[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (set_mask[i])
                    age_q[i] <= 8'd0;
                else if (pending_q[i] && age_q[i] != 8'hFF)
                    age_q[i] <= age_q[i] + 8'd1;
            end
        end
    end

    // Descending scan so the lowest urgent floor is the one left standing.
    always_comb begin
        urgent_any = 1'b0;
        urgent_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i] && age_q[i] >= AGE_LIM8) begin
                urgent_any = 1'b1;
                urgent_idx = 3'(i);
            end
        end
    end
`else
    logic [31:0] age_limit_unused;
    assign age_limit_unused = AGE_LIMIT;
    assign urgent_any       = 1'b0;
    assign urgent_idx       = 3'd0;
`endif

    always_comb begin
        diff1 = (bus.current_floor1 >= cand_q) ? bus.current_floor1 - cand_q
                                               : cand_q - bus.current_floor1;
        diff2 = (bus.current_floor2 >= cand_q) ? bus.current_floor2 - cand_q
                                               : cand_q - bus.current_floor2;
        cost1 = {1'b0, diff1} + {3'b000, bus.status1 == 2'b01};
        cost2 = {1'b0, diff2} + {3'b000, bus.status2 == 2'b01};
        elig1 = ~(bus.emergency_stop1 | bus.full_capacity1);
        elig2 = ~(bus.emergency_stop2 | bus.full_capacity2);
        // On a cost tie the lift that did not win last time takes the call.
        pick2 = elig2 & (~elig1 | (cost2 < cost1) | ((cost2 == cost1) & ~last_q));
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | set_mask;
        rr_ptr_d  = rr_ptr_q;
        cand_d    = cand_q;
        last_d    = last_q;
        win_d     = win_q;
        valid1_d  = 1'b0;
        valid2_d  = 1'b0;
        floor1_d  = floor1_q;
        floor2_d  = floor2_q;
        count1_d  = count1_q;
        count2_d  = count2_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    cand_d  = urgent_any ? urgent_idx : rr_pick(pending_q, rr_ptr_q);
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (!elig1 && !elig2) begin
                    rr_ptr_d = cand_q + 3'd1;
                    state_d  = IDLE;
                end else begin
                    win_d    = pick2;
                    valid1_d = ~pick2;
                    valid2_d = pick2;
                    if (pick2) floor2_d = cand_q;
                    else       floor1_d = cand_q;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                pending_d[cand_q] = 1'b0;
                rr_ptr_d          = cand_q + 3'd1;
                last_d            = win_q;
                if (win_q) begin
                    if (count2_q != 8'hFF) count2_d = count2_q + 8'd1;
                end else begin
                    if (count1_q != 8'hFF) count1_d = count1_q + 8'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= 8'd0;
            rr_ptr_q  <= 3'd0;
            cand_q    <= 3'd0;
            last_q    <= 1'b1;
            win_q     <= 1'b0;
            valid1_q  <= 1'b0;
            valid2_q  <= 1'b0;
            floor1_q  <= 3'd0;
            floor2_q  <= 3'd0;
            count1_q  <= 8'd0;
            count2_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            cand_q    <= cand_d;
            last_q    <= last_d;
            win_q     <= win_d;
            valid1_q  <= valid1_d;
            valid2_q  <= valid2_d;
            floor1_q  <= floor1_d;
            floor2_q  <= floor2_d;
            count1_q  <= count1_d;
            count2_q  <= count2_d;
        end
    end

    assign bus.assign_valid1 = valid1_q;
    assign bus.assign_valid2 = valid2_q;
    assign bus.assign_floor1 = floor1_q;
    assign bus.assign_floor2 = floor2_q;
    assign bus.pending       = pending_q;
    assign bus.assign_count1 = count1_q;
    assign bus.assign_count2 = count2_q;

endmodule

`default_nettype wire

// File: tb/tb_lift_dispatcher.sv
// ----------------------------------------------------------------------------
// tb_lift_dispatcher : scoreboard bench for lift_dispatcher
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lift_dispatcher;

`ifdef DISPATCH_AGE_EN
    localparam int unsigned AGE_LIM = 2;
`else
    localparam int unsigned AGE_LIM = 15;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    lift_dispatcher_if bus();

    lift_dispatcher #(.AGE_LIMIT(AGE_LIM)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] sb[$];          // {lift2?, floor}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (reset_n && (bus.assign_valid1 === 1'b1 || bus.assign_valid2 === 1'b1)) begin
            logic [3:0] exp_a;
            check("excl", {31'b0, bus.assign_valid1 & bus.assign_valid2}, 32'd0);
            check("sb_nonempty", {31'b0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                exp_a = sb.pop_front();
                check("assign", {28'b0, bus.assign_valid2,
                      bus.assign_valid2 ? bus.assign_floor2 : bus.assign_floor1}, {28'b0, exp_a});
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic call(input logic [2:0] f);
        int n = 0;
        bus.hall_valid = 1'b1;
        bus.hall_floor = f;
        #1;
        while (!bus.hall_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 100) check("call_ready", {31'b0, bus.hall_ready}, 32'd1);
        @(negedge clk);
        bus.hall_valid = 1'b0;
    endtask

    task automatic wait_clear();
        int n = 0;
        #1;
        while ((bus.pending != 8'd0 || bus.assign_valid1 || bus.assign_valid2) && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 100) check("timeout_pending", {24'b0, bus.pending}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hall_valid = 0; bus.hall_floor = 0;
        bus.current_floor1 = 3'd0; bus.current_floor2 = 3'd6;
        bus.status1 = 2'b00; bus.status2 = 2'b00;
        bus.emergency_stop1 = 0; bus.emergency_stop2 = 0;
        bus.full_capacity1 = 0; bus.full_capacity2 = 0;

        repeat (2) step();
        #1;
        check("rst_ready",   {31'b0, bus.hall_ready}, 32'd1);
        check("rst_pending", {24'b0, bus.pending}, 32'd0);
        check("rst_valid",   {30'b0, bus.assign_valid1, bus.assign_valid2}, 32'd0);
        check("rst_floors",  {26'b0, bus.assign_floor1, bus.assign_floor2}, 32'd0);
        check("rst_counts",  {16'b0, bus.assign_count1, bus.assign_count2}, 32'd0);
        step();
        reset_n = 1'b1;

        // Nearest lift takes floor 5, pulse lands two cycles after acceptance.
        sb.push_back({1'b1, 3'd5});
        call(3'd5);
        step(); step();
        check("s1_valid2", {31'b0, bus.assign_valid2}, 32'd1);
        check("s1_floor2", {29'b0, bus.assign_floor2}, 32'd5);
        step();
        check("s1_pending", {24'b0, bus.pending}, 32'd0);
        check("s1_count2",  {24'b0, bus.assign_count2}, 32'd1);

        // Equal costs alternate between lifts.
        bus.current_floor1 = 3'd2; bus.current_floor2 = 3'd2;
        sb.push_back({1'b0, 3'd4});
        sb.push_back({1'b1, 3'd0});
        call(3'd4);
        call(3'd0);
        wait_clear();
        check("s2_count1", {24'b0, bus.assign_count1}, 32'd1);
        check("s2_count2", {24'b0, bus.assign_count2}, 32'd2);

        // Both lifts blocked: call stays pending until lift 2 frees up.
        bus.emergency_stop1 = 1; bus.full_capacity2 = 1;
        call(3'd3);
        repeat (10) step();
        check("s3_pending", {24'b0, bus.pending}, 32'h08);
        sb.push_back({1'b1, 3'd3});
        bus.full_capacity2 = 0;
        wait_clear();
        bus.emergency_stop1 = 0;
        check("s3_count2", {24'b0, bus.assign_count2}, 32'd3);

        // Duplicate call held off until the ISSUE exit edge.
        sb.push_back({1'b0, 3'd6});
        bus.hall_valid = 1; bus.hall_floor = 3'd6;
        #1 check("s4_ready_pre", {31'b0, bus.hall_ready}, 32'd1);
        step(); #1 check("s4_ready_e0", {31'b0, bus.hall_ready}, 32'd0);
        step(); #1 check("s4_ready_e1", {31'b0, bus.hall_ready}, 32'd0);
        step(); #1 check("s4_ready_e2", {31'b0, bus.hall_ready}, 32'd0);
        check("s4_valid1", {31'b0, bus.assign_valid1}, 32'd1);
        step(); #1 check("s4_ready_e3", {31'b0, bus.hall_ready}, 32'd1);
        bus.hall_valid = 0;
        check("s4_pending", {24'b0, bus.pending}, 32'd0);

        // Floors 1 and 7 pending with the pointer moved to 2.
        bus.emergency_stop1 = 1; bus.emergency_stop2 = 1;
        bus.hall_valid = 1; bus.hall_floor = 3'd1;
        step();
        bus.hall_floor = 3'd7;
        step();
        bus.hall_valid = 0;
        step();
        check("s5_pending", {24'b0, bus.pending}, 32'h82);
`ifdef DISPATCH_AGE_EN
        sb.push_back({1'b1, 3'd1});
        sb.push_back({1'b0, 3'd7});
`else
        sb.push_back({1'b1, 3'd7});
        sb.push_back({1'b0, 3'd1});
`endif
        bus.emergency_stop1 = 0; bus.emergency_stop2 = 0;
        wait_clear();

        // Reset while a candidate is in flight.
        bus.current_floor1 = 3'd0; bus.current_floor2 = 3'd6;
        bus.hall_valid = 1; bus.hall_floor = 3'd5;
        step();
        bus.hall_valid = 0;
        step();
        reset_n = 1'b0;
        #1;
        check("s6_pending", {24'b0, bus.pending}, 32'd0);
        check("s6_counts",  {16'b0, bus.assign_count1, bus.assign_count2}, 32'd0);
        step();
        reset_n = 1'b1;
        repeat (4) step();
        check("s6_quiet", {30'b0, bus.assign_valid1, bus.assign_valid2}, 32'd0);
        check("s6_ready", {31'b0, bus.hall_ready}, 32'd1);

        // A moving lift pays one extra unit of cost.
        bus.current_floor1 = 3'd3; bus.current_floor2 = 3'd5;
        bus.status1 = 2'b01;
        sb.push_back({1'b1, 3'd4});
        call(3'd4);
        wait_clear();
        bus.status1 = 2'b00;

        // Lift 1 count saturates.
        bus.emergency_stop2 = 1; bus.current_floor1 = 3'd0;
        for (int i = 0; i < 256; i++) begin
            sb.push_back({1'b0, 3'(i)});
            call(3'(i));
            wait_clear();
        end
        bus.emergency_stop2 = 0;
        check("sat_count1", {24'b0, bus.assign_count1}, 32'd255);
        check("sat_count2", {24'b0, bus.assign_count2}, 32'd1);

        repeat (3) step();
        check("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
